// File: rtl/i2c_cond_gen.sv
// i2c_cond_gen: I2C START / repeated-START / STOP condition generator.
//
// Drives open-drain SDA/SCL (1 = release, 0 = pull low) through one request/ready handshake.
// It checks the bus state before acting, waits for slave clock stretching, checks
// arbitration on the lines it releases, and reports a status code with o_done.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req, i_cmd[1:0]        command request (0 START, 1 RESTART, 2 STOP, 3 illegal)
//   o_ready                  idle, a command can be accepted
//   o_done, o_err[1:0]       completion pulse and status (0 ok, 1 illegal, 2 arb lost,
//                            3 stretch timeout); o_err reads 0 outside o_done
//   i_sda, i_scl             synchronised line levels
//   o_sda_drive, o_scl_drive registered open-drain drives
//
// Build option: define I2C_STRETCH_TIMEOUT_EN to abort with status 3 when SCL is held low
// for STRETCH_MAX cycles. Without it, a stretch is waited out indefinitely.
module i2c_cond_gen #(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned I2C_FREQ    = 100_000,
  parameter int unsigned STRETCH_MAX = 25_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic [1:0] i_cmd,
  output logic       o_ready,
  output logic       o_done,
  output logic [1:0] o_err,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda_drive,
  output logic       o_scl_drive
);

  localparam int unsigned Q  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned CW = $clog2(Q + 1);

  localparam logic [1:0] CmdStart   = 2'd0;
  localparam logic [1:0] CmdRestart = 2'd1;
  localparam logic [1:0] CmdStop    = 2'd2;

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrIllegal = 2'd1;
  localparam logic [1:0] ErrArb     = 2'd2;

  if (Q < 1) begin : g_q_check
    $error("i2c_cond_gen: CLK_FREQ must be at least 4*I2C_FREQ");
  end
  if (STRETCH_MAX < 1) begin : g_stretch_check
    $error("i2c_cond_gen: STRETCH_MAX must be at least 1");
  end

  typedef enum logic [3:0] {
    StIdle, StCheck, StSdaHi, StSclHi, StStretch, StSdaLo, StSclLo, StSdaRel, StWait, StDone
  } state_e;

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;     // where WAIT goes when the quarter period expires
  logic            smp_q, smp_d;     // check SDA for arbitration at the end of WAIT
  logic [1:0]      cmd_q, cmd_d;
  logic [1:0]      err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sda_q, sda_d;
  logic            scl_q, scl_d;
  logic            abort;

`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int unsigned SW = $clog2(STRETCH_MAX + 1);
  localparam logic [1:0] ErrStretch = 2'd3;
  logic [SW-1:0] scnt_q, scnt_d;
`endif

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    smp_d   = smp_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    sda_d   = sda_q;
    scl_d   = scl_q;
    abort   = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
    scnt_d  = scnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          cmd_d   = i_cmd;
          err_d   = ErrOk;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // A failed precondition leaves the lines untouched.
        state_d = StDone;
        err_d   = ErrIllegal;
        unique case (cmd_q)
          CmdStart: begin
            if (i_scl && i_sda) begin
              state_d = StSdaLo;
              err_d   = ErrOk;
            end
          end
          CmdRestart: begin
            if (!i_scl) begin
              state_d = StSdaHi;
              err_d   = ErrOk;
            end
          end
          CmdStop: begin
            if (!i_scl) begin
              state_d = StSdaLo;
              err_d   = ErrOk;
            end
          end
          default: ;
        endcase
      end
      StSdaLo: begin
        state_d = StWait;
        cnt_d   = CW'(Q);
        smp_d   = 1'b0;
        ret_d   = (cmd_q == CmdStop) ? StSclHi : StSclLo;
      end
      StSclLo: begin
        state_d = StWait;
        cnt_d   = CW'(Q);
        smp_d   = 1'b0;
        ret_d   = StDone;
      end
      StSdaHi: begin
        state_d = StWait;
        cnt_d   = CW'(Q);
        smp_d   = 1'b1;
        ret_d   = StSclHi;
      end
      StSdaRel: begin
        state_d = StWait;
        cnt_d   = CW'(Q);
        smp_d   = 1'b1;
        ret_d   = StDone;
      end
      StSclHi, StStretch: begin
        if (i_scl) begin
          state_d = StWait;
          cnt_d   = CW'(Q);
          smp_d   = 1'b0;
          ret_d   = (cmd_q == CmdRestart) ? StSdaLo : StSdaRel;
        end else if (state_q == StSclHi) begin
          state_d = StStretch;
`ifdef I2C_STRETCH_TIMEOUT_EN
          scnt_d  = '0;
`endif
        end else begin
`ifdef I2C_STRETCH_TIMEOUT_EN
          // scnt_q counts completed STRETCH cycles; this is the last one allowed.
          if (scnt_q == SW'(STRETCH_MAX - 1)) begin
            abort   = 1'b1;
            err_d   = ErrStretch;
            state_d = StDone;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
`endif
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (smp_q && !i_sda) begin
            abort   = 1'b1;
            err_d   = ErrArb;
            state_d = StDone;
          end else begin
            state_d = ret_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Drives are registered against the state being entered, so each drive state's edge is
    // visible on its first cycle.
    case (state_d)
      StSdaLo:           sda_d = 1'b0;
      StSdaHi, StSdaRel: sda_d = 1'b1;
      StSclLo:           scl_d = 1'b0;
      StSclHi:           scl_d = 1'b1;
      default: ;
    endcase
    if (abort) begin
      sda_d = 1'b1;
      scl_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
      smp_q   <= 1'b0;
      cmd_q   <= 2'd0;
      err_q   <= ErrOk;
      cnt_q   <= '0;
      sda_q   <= 1'b1;
      scl_q   <= 1'b1;
`ifdef I2C_STRETCH_TIMEOUT_EN
      scnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      smp_q   <= smp_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sda_q   <= sda_d;
      scl_q   <= scl_d;
`ifdef I2C_STRETCH_TIMEOUT_EN
      scnt_q  <= scnt_d;
`endif
    end
  end

  assign o_ready     = (state_q == StIdle);
  assign o_done      = (state_q == StDone);
  assign o_err       = o_done ? err_q : ErrOk;
  assign o_sda_drive = sda_q;
  assign o_scl_drive = scl_q;

endmodule

// File: tb/tb_i2c_cond_gen.sv
module tb_i2c_cond_gen;

  localparam int unsigned CLK_FREQ    = 400_000;
  localparam int unsigned I2C_FREQ    = 10_000;
  localparam int unsigned STRETCH_MAX = 100;
  localparam int          Q           = CLK_FREQ / (4 * I2C_FREQ);
  localparam int          S           = Q + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] cmd;
  logic       ready, done;
  logic [1:0] err;
  logic       sda_drv, scl_drv;
  logic       bus_sda, bus_scl;

  // Bus model: a slave may hold SCL low for hold_len cycles after it is released, and
  // sda_force models another master pulling SDA low.
  logic        sda_force;
  int unsigned hold_len;
  int unsigned scl_hi_cnt;

  assign bus_scl = scl_drv && (scl_hi_cnt >= hold_len);
  assign bus_sda = sda_drv && !sda_force;

  always #5 clk = ~clk;

  always @(posedge clk) scl_hi_cnt <= scl_drv ? scl_hi_cnt + 1 : 0;

  i2c_cond_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .I2C_FREQ   (I2C_FREQ),
    .STRETCH_MAX(STRETCH_MAX)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_cmd      (cmd),
    .o_ready    (ready),
    .o_done     (done),
    .o_err      (err),
    .i_sda      (bus_sda),
    .i_scl      (bus_scl),
    .o_sda_drive(sda_drv),
    .o_scl_drive(scl_drv)
  );

  int   checks   = 0;
  int   failures = 0;
  logic cur_sda, cur_scl;   // drive levels the model expects between commands

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected drive traces (cycle 0 = accept), done cycle and status, built
  // from the edge list of each command with edge spacing S plus any stretch.
  task automatic model(input int c, input logic s0, input logic c0, input int unsigned n,
                       input logic frc, output logic [255:0] es, output logic [255:0] ec,
                       output int ed, output logic [1:0] ee);
    int   tm[4];
    logic sig[4];   // 1 = SCL edge, 0 = SDA edge
    logic val[4];
    int   ne, nu, arb, t;
    logic legal, ab, s, k;
    es = '0; ec = '0; ee = 2'd0; ab = 1'b0; ne = 0; arb = -1; ed = 0;
    legal = (c == 0 && c0 && s0 && !frc) || ((c == 1 || c == 2) && !c0);
    if (!legal) begin
      ed = 2; ee = 2'd1;
      for (int y = 0; y <= 2; y++) begin es[y] = s0; ec[y] = c0; end
      return;
    end
    if (c == 0) begin
      ne = 2; sig[0] = 0; val[0] = 0; sig[1] = 1; val[1] = 0;
    end else if (c == 1) begin
      ne = 4; arb = 0;
      sig[0] = 0; val[0] = 1; sig[1] = 1; val[1] = 1;
      sig[2] = 0; val[2] = 0; sig[3] = 1; val[3] = 0;
    end else begin
      ne = 3; arb = 2;
      sig[0] = 0; val[0] = 0; sig[1] = 1; val[1] = 1; sig[2] = 0; val[2] = 1;
    end
    t = 2; nu = ne;
    for (int e = 0; e < ne; e++) begin
      tm[e] = t;
      if (sig[e] && val[e] && n > 0) begin
`ifdef I2C_STRETCH_TIMEOUT_EN
        if (n > STRETCH_MAX) begin
          nu = e + 1; ed = t + int'(STRETCH_MAX) + 1; ee = 2'd3; ab = 1'b1;
          break;
        end
`endif
        t += int'(n);
      end
      t += S;
      if (e == arb && frc) begin
        nu = e + 1; ed = t; ee = 2'd2; ab = 1'b1;
        break;
      end
    end
    if (!ab) ed = t;
    for (int y = 0; y <= ed && y < 256; y++) begin
      s = s0; k = c0;
      for (int e = 0; e < nu; e++) begin
        if (tm[e] <= y) begin
          if (sig[e]) k = val[e]; else s = val[e];
        end
      end
      if (ab && y == ed) begin s = 1'b1; k = 1'b1; end
      es[y] = s; ec[y] = k;
    end
  endtask

  task automatic run(input int c, input int unsigned n, input logic frc);
    logic [255:0] es, ec, as, ac;
    int           ed, ad;
    logic [1:0]   ee, ae;
    model(c, cur_sda, cur_scl, n, frc, es, ec, ed, ee);
    hold_len  = ((c == 1 || c == 2) && !cur_scl) ? n : 0;
    sda_force = frc;
    as = '0; ac = '0; ad = -1; ae = 2'd0;
    @(negedge clk);
    chk("ready_before", {255'd0, ready}, 256'd1);
    req = 1'b1;
    cmd = 2'(c);
    as[0] = sda_drv; ac[0] = scl_drv;
    for (int y = 1; y < 256; y++) begin
      @(negedge clk);
      as[y] = sda_drv; ac[y] = scl_drv;
      if (done) begin ad = y; ae = err; break; end
    end
    chk($sformatf("done_cycle cmd%0d", c), 256'(ad), 256'(ed));
    chk($sformatf("status cmd%0d", c), 256'(ae), 256'(ee));
    chk($sformatf("sda_trace cmd%0d", c), as, es);
    chk($sformatf("scl_trace cmd%0d", c), ac, ec);
    // i_req still high here: the block must be idle again and not have retriggered.
    @(negedge clk);
    chk("ready_after_done", {254'd0, ready, done}, 256'd2);
    req = 1'b0;
    hold_len = 0;
    sda_force = 1'b0;
    cur_sda = es[ed];
    cur_scl = ec[ed];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_sda = 1'b1;
    cur_scl = 1'b1;
  endtask

  int   dir_c[9] = '{0, 2, 0, 1, 2, 0, 3, 0, 1};
  int   dir_n[9] = '{0, 0, 0, 50, 0, 0, 0, 0, 0};
  logic dir_f[9] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
  int   dones;

  initial begin
    req = 1'b0; cmd = 2'd0; sda_force = 1'b0; hold_len = 0; rst = 1'b0;
    do_reset();
    @(negedge clk);
    chk("reset_state", {250'd0, sda_drv, scl_drv, ready, done, err}, {250'd0, 6'b111000});

    // START, STOP, START, stretched RESTART, STOP with lost arbitration, START on busy SDA,
    // illegal command, START, RESTART with lost arbitration.
    for (int i = 0; i < 9; i++) run(dir_c[i], dir_n[i], dir_f[i]);

    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 3)),
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0,
          ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a RESTART: SDA has just been pulled low again.
    do_reset();
    run(0, 0, 1'b0);
    @(negedge clk);
    req = 1'b1; cmd = 2'd1;
    @(negedge clk);
    req = 1'b0;
    repeat (29) @(negedge clk);
    chk("restart_mid_drives", {254'd0, sda_drv, scl_drv}, 256'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_cmd", {252'd0, sda_drv, scl_drv, ready, done}, {252'd0, 4'b1110});
    rst = 1'b0;
    cur_sda = 1'b1; cur_scl = 1'b1;

    // SCL held low forever during STOP.
    run(0, 0, 1'b0);
`ifdef I2C_STRETCH_TIMEOUT_EN
    run(2, 32'hFFFF_FFFF, 1'b0);
`else
    hold_len = 32'hFFFF_FFFF;
    @(negedge clk);
    req = 1'b1; cmd = 2'd2;
    @(negedge clk);
    req = 1'b0;
    dones = 0;
    repeat (10_000) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("no_done_while_stretched", 256'(dones), 256'd0);
    hold_len = 0;
    do_reset();
`endif
    run(0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_cond_gen.md
# i2c_cond_gen

Parametrised I2C bus-condition generator for the I2C master datapath. It produces START, repeated-START and STOP conditions on open-drain SDA/SCL drives under one request/ready handshake. It honours slave clock stretching, checks bus state and arbitration, and reports a per-command status code. It sits between the I2C transaction sequencer and the open-drain pad muxing, alongside the bit/byte shifter, which owns the lines between conditions.

## Interface
- CLK_FREQ, 25_000_000: system clock frequency, Hz.
- I2C_FREQ, 100_000: SCL frequency, Hz; quarter period Q = CLK_FREQ/(4*I2C_FREQ), must be ≥ 1.
- STRETCH_MAX, 25_000: maximum i_clk cycles SCL may be held low by a slave (used only with I2C_STRETCH_TIMEOUT_EN).
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  command request.
- i_cmd  in  2  0=START, 1=RESTART, 2=STOP, 3=reserved/illegal; sampled on accept.
- o_ready  out  1  high when the block is idle and can accept a command.
- o_done  out  1  one-cycle pulse when the command completes or aborts.
- o_err  out  2  status, valid only while o_done is high: 0=ok, 1=illegal, 2=arbitration lost, 3=stretch timeout.
- i_sda, i_scl  in  1 each  synchronised line levels.
- o_sda_drive, o_scl_drive  out  1 each  1=release (high), 0=pull low; both registered.

## Operation
- States: IDLE, CHECK, SDA_HI, SCL_HI, STRETCH, SDA_LO, SCL_LO, SDA_REL, WAIT, DONE. WAIT loads the counter with Q, decrements to 0, then jumps to the stored return state.
- Accept: i_req & o_ready; o_ready = (state==IDLE). i_cmd is latched, then CHECK evaluates preconditions.
- Preconditions:
  - START requires i_scl=1 and i_sda=1.
  - RESTART and STOP require i_scl=0.
  - A failed precondition or cmd=3 → DONE with err 1; the lines are untouched.
- START: SDA_LO → WAIT → SCL_LO → WAIT → DONE.
- RESTART:
  - SDA_HI → WAIT, then sample i_sda; 0 → err 2.
  - SCL_HI → STRETCH until i_scl=1 → WAIT.
  - SDA_LO → WAIT → SCL_LO → WAIT → DONE.
- STOP:
  - SDA_LO → WAIT.
  - SCL_HI → STRETCH → WAIT.
  - SDA_REL → WAIT, then sample i_sda; 0 → err 2.
  - DONE.
- STRETCH: the block waits as long as i_scl=0 after o_scl_drive has been released. WAIT begins on the first cycle i_scl=1.
- Abort (err 2 or 3): both drives release, then DONE.
- Counter width $clog2(Q+1); stretch counter width $clog2(STRETCH_MAX+1).
- No new request is accepted in DONE; IDLE follows DONE.

## Timing
- Reset values: o_sda_drive=1, o_scl_drive=1, o_ready=1, o_done=0, o_err=0, state IDLE. A reset mid-command aborts immediately, releases both lines the next cycle, and does not pulse o_done.
- Accept at cycle 0 → CHECK at cycle 1 → the first drive change is registered out at cycle 2.
- Drive-edge spacing S = Q+2 cycles: 1 drive-state cycle plus Q+1 WAIT cycles. Stretch cycles are added on top of S.
- o_done is asserted for 1 cycle, Q+2 cycles after the last drive edge. o_ready rises the cycle after o_done.
- Illegal command: o_done with err 1 at cycle 2, with no drive change.
- i_req held high through DONE does not retrigger until o_ready=1.

## Configuration
- I2C_STRETCH_TIMEOUT_EN defined: a stretch counter runs in STRETCH. On reaching STRETCH_MAX cycles the block aborts with err 3.
- Not defined: STRETCH waits indefinitely, err 3 is never produced, and STRETCH_MAX is unused.

## Test plan
All scenarios use CLK_FREQ=400_000 and I2C_FREQ=10_000, giving Q=10 and S=12.
- Idle bus, START at cycle 0 → o_sda_drive falls at cycle 2, o_scl_drive falls at cycle 14, o_done with err 0 at cycle 26.
- Following a START (SCL low), STOP with no stretching → SDA low at cycle 2, SCL released at 14, SDA released at 26, done with err 0 at 38; both drives end at 1.
- RESTART with a slave holding i_scl=0 for 50 cycles after release → the remaining edges shift by exactly 50 cycles; done with err 0.
- STOP with i_sda forced to 0 at the final sample → o_done with err 2; both drives released.
- START while i_sda=0, or cmd=3 → o_done with err 1 at cycle 2; drives stay at 1. Assert i_rst mid-RESTART → drives return to 1 the next cycle, no o_done, o_ready=1.
- With I2C_STRETCH_TIMEOUT_EN and STRETCH_MAX=100, hold i_scl=0 forever during STOP → o_done with err 3 after 100 STRETCH cycles. Without the macro, no o_done appears within 10_000 cycles.
